// File: rtl/caesar_channel_arbiter_if.sv
// rtl/caesar_channel_arbiter_if.sv - requester, engine and output signals of the caesar channel arbiter
interface caesar_channel_arbiter_if #(
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 16,
    parameter int N_CH      = 4
);
    localparam int CW = $clog2(N_CH);

    logic [N_CH-1:0]           req_valid;
    logic [N_CH*D_WIDTH-1:0]   req_data;
    logic [N_CH*KEY_WIDTH-1:0] req_key;
    logic [N_CH-1:0]           req_ready;
    logic [D_WIDTH-1:0]        eng_data_o;
    logic                      eng_valid_o;
    logic [KEY_WIDTH-1:0]      eng_key_o;
    logic                      eng_busy_i;
    logic [D_WIDTH-1:0]        eng_data_i;
    logic                      eng_valid_i;
    logic [D_WIDTH-1:0]        out_data;
    logic                      out_valid;
    logic [CW-1:0]             out_chan;

    modport slave (
        input  req_valid, req_data, req_key, eng_busy_i, eng_data_i, eng_valid_i,
        output req_ready, eng_data_o, eng_valid_o, eng_key_o, out_data, out_valid, out_chan
    );

    modport master (
        output req_valid, req_data, req_key, eng_busy_i, eng_data_i, eng_valid_i,
        input  req_ready, eng_data_o, eng_valid_o, eng_key_o, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/caesar_channel_arbiter.sv
// rtl/caesar_channel_arbiter.sv - round-robin message arbiter feeding one decryption engine
// Optional lock timeout enabled by defining ARB_TIMEOUT_EN.
module caesar_channel_arbiter #(
    parameter int                  D_WIDTH   = 8,
    parameter int                  KEY_WIDTH = 16,
    parameter int                  N_CH      = 4,
    parameter logic [D_WIDTH-1:0]  TERM_CHAR = 8'hFA
) (
    input  logic clk,
    input  logic rst_n,
    caesar_channel_arbiter_if.slave bus
);
    localparam int CW = $clog2(N_CH);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]           state;
    logic [CW-1:0]        owner;
    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        ch_s1;
    logic [CW-1:0]        ch_s2;
    logic [CW-1:0]        owner_next;
    logic [CW-1:0]        grant_idx;
    logic                 grant_found;
    logic [KEY_WIDTH-1:0] grant_key;
    logic [D_WIDTH-1:0]   owner_data;
    logic                 xfer;

    assign xfer       = (state == LOCKED) && bus.req_valid[owner] && !bus.eng_busy_i;
    assign owner_next = (int'(owner) == N_CH - 1) ? '0 : owner + CW'(1);

    // Lowest offset from rr_ptr wins, so scan offsets from high to low.
    always_comb begin
        logic [CW-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = CW'((int'(rr_ptr) + i) % N_CH);
            if (bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        grant_key  = '0;
        owner_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_idx == CW'(k)) grant_key  = bus.req_key[k*KEY_WIDTH +: KEY_WIDTH];
            if (owner == CW'(k))     owner_data = bus.req_data[k*D_WIDTH +: D_WIDTH];
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == LOCKED) bus.req_ready[owner] = !bus.eng_busy_i;
    end

    assign bus.out_data  = bus.eng_data_i;
    assign bus.out_valid = bus.eng_valid_i;
    assign bus.out_chan  = ch_s2;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       timeout;

    assign timeout = (idle_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE || xfer) begin
            idle_cnt <= '0;
        end else if (!bus.req_valid[owner] && !timeout) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            owner           <= '0;
            rr_ptr          <= '0;
            bus.eng_key_o   <= '0;
            bus.eng_data_o  <= '0;
            bus.eng_valid_o <= 1'b0;
            ch_s1           <= '0;
            ch_s2           <= '0;
        end else begin
            bus.eng_valid_o <= xfer;
            bus.eng_data_o  <= xfer ? owner_data : '0;
            ch_s2           <= ch_s1;
            if (xfer) ch_s1 <= owner;

            if (state == IDLE) begin
                if (grant_found) begin
                    owner         <= grant_idx;
                    bus.eng_key_o <= grant_key;
                    state         <= LOCKED;
                end
            end else if ((xfer && owner_data == TERM_CHAR) || timeout) begin
                state  <= IDLE;
                rr_ptr <= owner_next;
            end
        end
    end
endmodule

// File: tb/tb_caesar_channel_arbiter.sv
// tb/tb_caesar_channel_arbiter.sv - scoreboard bench for caesar_channel_arbiter with a 1-cycle subtract engine
module tb_caesar_channel_arbiter;
    localparam int N = 4;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    caesar_channel_arbiter_if #(.D_WIDTH(8), .KEY_WIDTH(16), .N_CH(N)) bus ();

    caesar_channel_arbiter #(.D_WIDTH(8), .KEY_WIDTH(16), .N_CH(N), .TERM_CHAR(8'hFA)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t        exp_q[$];
    int          xfer_q[$];
    int          out_cyc[$];
    logic [7:0]  chq[N][$];
    logic [15:0] keys[N];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine: subtract the low key byte, one register of latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.eng_valid_i <= 1'b0;
            bus.eng_data_i  <= 8'h00;
        end else begin
            bus.eng_valid_i <= bus.eng_valid_o;
            bus.eng_data_i  <= bus.eng_data_o - bus.eng_key_o[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic expect_out(input logic [1:0] ch, input logic [7:0] d);
        exp_t e;
        e.ch = ch;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            bus.req_valid[k]          = (chq[k].size() > 0);
            bus.req_data[k*8 +: 8]    = (chq[k].size() > 0) ? chq[k][0] : 8'h00;
            bus.req_key[k*16 +: 16]   = keys[k];
        end
    endtask

    // Requesters: a character leaves its queue when accepted at the edge.
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready & {N{rst_n}};
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    xfer_q.push_back(cyc);
                    void'(chq[k].pop_front());
                end
            end
            drive_inputs();
        end
    end

    // Monitor: cyc+1 is the edge at which this output is captured.
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got ch%0d data %0h required no output", bus.out_chan, bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_chan_data", {22'd0, bus.out_chan, bus.out_data}, {22'd0, e.ch, e.d});
            end
            if (xfer_q.size() == 0) begin
                n_chk++;
                $display("FAIL latency: got output with no transfer required a transfer 2 edges earlier");
            end else begin
                check("latency", cyc + 1 - xfer_q.pop_front(), 2);
            end
            out_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.eng_busy_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            chq[k].delete();
            keys[k] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        xfer_q.delete();
        out_cyc.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #2;
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic wait_size(input string name, input int ch, input int sz, input int budget);
        int n = 0;
        @(posedge clk);
        #2;
        while (chq[ch].size() != sz && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_wait"}, chq[ch].size(), sz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int seen;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_key    = '0;
        bus.eng_busy_i = 1'b0;
        for (int k = 0; k < N; k++) keys[k] = 16'h0;

        do_reset();
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_eng_valid", bus.eng_valid_o, 0);
        check("rst_eng_data", bus.eng_data_o, 0);
        check("rst_eng_key", bus.eng_key_o, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_chan", bus.out_chan, 0);

        // Single message on ch0, key 3: "D","E",TERM -> "A","B",F7
        @(posedge clk);
        #2;
        keys[0] = 16'd3;
        chq[0].push_back(8'h44); chq[0].push_back(8'h45); chq[0].push_back(8'hFA);
        expect_out(0, 8'h41); expect_out(0, 8'h42); expect_out(0, 8'hF7);
        wait_drain("t019", 60);

        // ch1 and ch2 together: ch1 whole message, then ch2 one idle cycle later
        do_reset();
        keys[1] = 16'd5;
        chq[1].push_back(8'h58); chq[1].push_back(8'hFA);
        keys[2] = 16'd7;
        chq[2].push_back(8'h51); chq[2].push_back(8'h52); chq[2].push_back(8'hFA);
        expect_out(1, 8'h53); expect_out(1, 8'hF5);
        expect_out(2, 8'h4A); expect_out(2, 8'h4B); expect_out(2, 8'hF3);
        wait_drain("t020", 60);
        check("t020_count", out_cyc.size(), 5);
        if (out_cyc.size() == 5) check("t020_gap", out_cyc[2] - out_cyc[1], 2);

        // All channels, TERM-only messages: order 0,1,2,3,0
        do_reset();
        for (int k = 0; k < N; k++) begin
            keys[k] = 16'(k + 1);
            chq[k].push_back(8'hFA);
        end
        chq[0].push_back(8'hFA);
        expect_out(0, 8'hF9); expect_out(1, 8'hF8); expect_out(2, 8'hF7);
        expect_out(3, 8'hF6); expect_out(0, 8'hF9);
        wait_drain("t021", 80);

        // Engine busy for 3 cycles after two characters of ch2
        do_reset();
        keys[2] = 16'd1;
        chq[2].push_back(8'h62); chq[2].push_back(8'h63); chq[2].push_back(8'h64);
        chq[2].push_back(8'h65); chq[2].push_back(8'hFA);
        expect_out(2, 8'h61); expect_out(2, 8'h62); expect_out(2, 8'h63);
        expect_out(2, 8'h64); expect_out(2, 8'hF9);
        wait_size("t022", 2, 3, 40);
        bus.eng_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t022_ready_busy", bus.req_ready, 0);
            @(posedge clk);
            #2;
        end
        bus.eng_busy_i = 1'b0;
        wait_drain("t022", 60);

        // Reset after 2 of 5 characters; second one is abandoned in flight
        do_reset();
        keys[0] = 16'd2;
        chq[0].push_back(8'h68); chq[0].push_back(8'h65); chq[0].push_back(8'h6C);
        chq[0].push_back(8'h6C); chq[0].push_back(8'hFA);
        expect_out(0, 8'h66);
        wait_size("t023", 0, 3, 40);
        rst_n = 1'b0;
        chq[0].delete();
        keys[3] = 16'd4;
        chq[3].push_back(8'h5A); chq[3].push_back(8'hFA);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        xfer_q.delete();
        @(negedge clk);
        check("t023_eng_valid", bus.eng_valid_o, 0);
        check("t023_eng_data", bus.eng_data_o, 0);
        check("t023_eng_key", bus.eng_key_o, 0);
        check("t023_req_ready", bus.req_ready, 0);
        check("t023_out_valid", bus.out_valid, 0);
        check("t023_out_chan", bus.out_chan, 0);
        expect_out(3, 8'h56); expect_out(3, 8'hF6);
        @(negedge clk);
        check("t023_grant_ch3", bus.req_ready, 4'b1000);
        check("t023_key_ch3", bus.eng_key_o, 16'd4);
        wait_drain("t023", 40);

        // ch0 stalls after one character while ch1 waits
        do_reset();
        keys[0] = 16'd9;
        chq[0].push_back(8'h61);
        keys[1] = 16'd1;
        chq[1].push_back(8'hFA);
        expect_out(0, 8'h58);
`ifdef ARB_TIMEOUT_EN
        expect_out(1, 8'hF9);
        wait_drain("t024", 600);
        check("t024_ch1_done", chq[1].size(), 0);
`else
        wait_drain("t024", 40);
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.req_ready[1]) seen++;
        end
        check("t024_no_grant", seen, 0);
        check("t024_ch1_pending", chq[1].size(), 1);
`endif

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
